// File: rtl/datapath_sequencer.sv
// Multi-cycle IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for an RV32I datapath.
// Define SEQ_PERF_COUNTERS_EN to add cycle and retired-instruction counters.
module datapath_sequencer #(
    parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    parameter int CNT_WIDTH   = 64
`endif
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [31:0] i_Inst,
    input  logic        i_RegWrEnable,
    input  logic        i_MemWrEnable,
    input  logic        i_Halt,
    input  logic        i_IMemReady,
    input  logic        i_DMemReady,
    output logic        o_IMemReq,
    output logic        o_IRLoad,
    output logic        o_DMemReq,
    output logic        o_MemWrEnable,
    output logic        o_RegWrEnable,
    output logic        o_PCUpdate,
    output logic        o_Retire,
    output logic [2:0]  o_Stage,
    output logic        o_Illegal,
    output logic        o_BusError
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] o_CycleCount,
    output logic [CNT_WIDTH-1:0] o_InstRetCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // A timeout of 0 disables the check but still needs a one-bit counter.
    localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              timeout;
    logic              legal, is_load, is_store;
    logic              ir_load, pc_update, mem_wr_gate, reg_wr_gate;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              unused_inst;

    assign opcode      = i_Inst[6:0];
    assign funct3      = i_Inst[14:12];
    assign unused_inst = ^{i_Inst[31:15], i_Inst[11:7]};

    always_comb begin
        legal    = 1'b0;
        is_load  = (opcode == OPC_LOAD);
        is_store = (opcode == OPC_STORE);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OPIMM, OPC_OP: legal = 1'b1;
            OPC_JALR:   legal = (funct3 == 3'b000);
            OPC_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            OPC_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            OPC_STORE:  legal = (funct3 <= 3'b010);
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        ir_load     = 1'b0;
        pc_update   = 1'b0;
        mem_wr_gate = 1'b0;
        reg_wr_gate = 1'b0;
        wait_inc    = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        // Ready in the limit cycle is checked first, so it always wins.
        timeout     = (MEM_TIMEOUT != 0) && (wait_inc == WAIT_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (!i_Halt) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (i_IMemReady) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        state_d   = S_ERROR;
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = S_ERROR;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else if (i_RegWrEnable) begin
                    state_d = S_WRITEBACK;
                end else begin
                    pc_update = 1'b1;
                end
            end
            S_MEMORY: begin
                mem_wr_gate = i_MemWrEnable;
                if (i_DMemReady) begin
                    if (is_load) state_d = S_WRITEBACK;
                    else         pc_update = 1'b1;
                end else begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        state_d   = S_ERROR;
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_wr_gate = i_RegWrEnable;
                pc_update   = 1'b1;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Every retire funnels through here so halt is only sampled at a boundary.
        if (pc_update) begin
            state_d = i_Halt ? S_IDLE : S_FETCH;
            wait_d  = '0;
        end

        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEMORY);
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
        end
    end

    assign o_IMemReq     = imem_req_q;
    assign o_DMemReq     = dmem_req_q;
    assign o_IRLoad      = ir_load;
    assign o_MemWrEnable = mem_wr_gate;
    assign o_RegWrEnable = reg_wr_gate;
    assign o_PCUpdate    = pc_update;
    assign o_Retire      = pc_update;
    assign o_Stage       = state_q;
    assign o_Illegal     = illegal_q;
    assign o_BusError    = bus_err_q;

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (state_q != S_IDLE && state_q != S_ERROR) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (pc_update)                               ret_cnt_d   = ret_cnt_q + 1'b1;
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            cycle_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign o_CycleCount   = cycle_cnt_q;
    assign o_InstRetCount = ret_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a per-cycle vector table for the normal
// instruction flow plus hand-written sequences for decode, timeout and reset corners.
module tb_datapath_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        regwr, memwr, halt, irdy, drdy;
    logic        o_IMemReq, o_IRLoad, o_DMemReq, o_MemWrEnable, o_RegWrEnable;
    logic        o_PCUpdate, o_Retire, o_Illegal, o_BusError;
    logic [2:0]  o_Stage;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] SW   = 32'h00112023;
    localparam logic [31:0] LW   = 32'h00012083;

    // Strobe order: imemreq irload dmemreq memwr regwr pcupdate retire
    localparam logic [6:0] ST_NONE  = 7'b0000000;
    localparam logic [6:0] ST_FETCH = 7'b1100000;
    localparam logic [6:0] ST_FWAIT = 7'b1000000;
    localparam logic [6:0] ST_WB    = 7'b0000111;
    localparam logic [6:0] ST_BR    = 7'b0000011;
    localparam logic [6:0] ST_SWAIT = 7'b0011000;
    localparam logic [6:0] ST_SDONE = 7'b0011011;
    localparam logic [6:0] ST_LMEM  = 7'b0010000;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        regwr, memwr, halt, irdy, drdy;
        logic [2:0]  stage;
        logic [6:0]  strobes;
    } row_t;

    typedef struct {
        logic [31:0] inst;
        logic        legal;
    } dec_t;

    row_t rows[$];
    dec_t decs[$];

    datapath_sequencer #(.MEM_TIMEOUT(16)) dut (
        .i_Clock       (clk),
        .i_Reset       (rst_n),
        .i_Inst        (inst),
        .i_RegWrEnable (regwr),
        .i_MemWrEnable (memwr),
        .i_Halt        (halt),
        .i_IMemReady   (irdy),
        .i_DMemReady   (drdy),
        .o_IMemReq     (o_IMemReq),
        .o_IRLoad      (o_IRLoad),
        .o_DMemReq     (o_DMemReq),
        .o_MemWrEnable (o_MemWrEnable),
        .o_RegWrEnable (o_RegWrEnable),
        .o_PCUpdate    (o_PCUpdate),
        .o_Retire      (o_Retire),
        .o_Stage       (o_Stage),
        .o_Illegal     (o_Illegal),
        .o_BusError    (o_BusError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic void add(input string n, input logic [31:0] i, input logic rw,
                                input logic mw, input logic h, input logic ir,
                                input logic dr, input logic [2:0] st, input logic [6:0] sb);
        row_t r;
        r.name = n; r.inst = i; r.regwr = rw; r.memwr = mw; r.halt = h;
        r.irdy = ir; r.drdy = dr; r.stage = st; r.strobes = sb;
        rows.push_back(r);
    endfunction

    function automatic void add_dec(input logic [31:0] i, input logic l);
        dec_t d;
        d.inst = i; d.legal = l;
        decs.push_back(d);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {o_Stage, o_IMemReq, o_IRLoad, o_DMemReq, o_MemWrEnable, o_RegWrEnable,
                o_PCUpdate, o_Retire, o_Illegal, o_BusError};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; halt = 1'b1; irdy = 1'b0; drdy = 1'b0;
        regwr = 1'b0; memwr = 1'b0; inst = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_row(input row_t r);
        inst = r.inst; regwr = r.regwr; memwr = r.memwr; halt = r.halt;
        irdy = r.irdy; drdy = r.drdy;
        @(negedge clk);
        check(r.name, {4'h0, outs()}, {4'h0, r.stage, r.strobes, 2'b00});
        tick();
    endtask

    initial begin
        int fetch_cycles;

        add("idle_halted",  ADDI, 1, 1, 1, 1, 1, 3'd0, ST_NONE);
        add("addi_idle",    ADDI, 1, 1, 0, 1, 1, 3'd0, ST_NONE);
        add("addi_fetch",   ADDI, 1, 1, 0, 1, 1, 3'd1, ST_FETCH);
        add("addi_decode",  ADDI, 1, 1, 0, 1, 1, 3'd2, ST_NONE);
        add("addi_execute", ADDI, 1, 1, 0, 1, 1, 3'd3, ST_NONE);
        add("addi_wb",      ADDI, 1, 1, 0, 1, 1, 3'd5, ST_WB);
        add("beq_fetch",    BEQ,  0, 1, 0, 1, 1, 3'd1, ST_FETCH);
        add("beq_decode",   BEQ,  0, 1, 0, 1, 1, 3'd2, ST_NONE);
        add("beq_execute",  BEQ,  0, 1, 0, 1, 1, 3'd3, ST_BR);
        add("sw_fetch",     SW,   1, 1, 0, 1, 0, 3'd1, ST_FETCH);
        add("sw_decode",    SW,   1, 1, 0, 1, 0, 3'd2, ST_NONE);
        add("sw_execute",   SW,   1, 1, 0, 1, 0, 3'd3, ST_NONE);
        add("sw_mem_w1",    SW,   1, 1, 0, 1, 0, 3'd4, ST_SWAIT);
        add("sw_mem_w2",    SW,   1, 1, 0, 1, 0, 3'd4, ST_SWAIT);
        add("sw_mem_w3",    SW,   1, 1, 0, 1, 0, 3'd4, ST_SWAIT);
        add("sw_mem_ack",   SW,   1, 1, 1, 1, 1, 3'd4, ST_SDONE);
        add("sw_halted",    SW,   1, 1, 1, 1, 1, 3'd0, ST_NONE);
        add("lw_idle",      LW,   1, 0, 0, 1, 1, 3'd0, ST_NONE);
        add("lw_fetch",     LW,   1, 0, 0, 1, 1, 3'd1, ST_FETCH);
        add("lw_decode",    LW,   1, 0, 0, 1, 1, 3'd2, ST_NONE);
        add("lw_execute",   LW,   1, 0, 0, 1, 1, 3'd3, ST_NONE);
        add("lw_mem",       LW,   1, 0, 0, 1, 1, 3'd4, ST_LMEM);
        add("lw_wb",        LW,   1, 0, 0, 1, 1, 3'd5, ST_WB);
        add("halt_fwait",   ADDI, 1, 0, 1, 0, 1, 3'd1, ST_FWAIT);
        add("halt_fetch",   ADDI, 1, 0, 1, 1, 1, 3'd1, ST_FETCH);
        add("halt_decode",  ADDI, 1, 0, 1, 1, 1, 3'd2, ST_NONE);
        add("halt_execute", ADDI, 1, 0, 1, 1, 1, 3'd3, ST_NONE);
        add("halt_wb",      ADDI, 1, 0, 1, 1, 1, 3'd5, ST_WB);
        add("halt_idle1",   ADDI, 1, 0, 1, 1, 1, 3'd0, ST_NONE);
        add("halt_idle2",   ADDI, 1, 0, 1, 1, 1, 3'd0, ST_NONE);

        add_dec(32'hFFFFFFFF, 0); add_dec(32'h00002063, 0); add_dec(32'h00003063, 0);
        add_dec(32'h00001067, 0); add_dec(32'h00000067, 1); add_dec(32'h00003003, 0);
        add_dec(32'h00006003, 0); add_dec(32'h00004003, 1); add_dec(32'h00003023, 0);
        add_dec(32'h000000B7, 1); add_dec(32'h00000017, 1); add_dec(32'h0000006F, 1);
        add_dec(32'h00000033, 1); add_dec(32'h0000000F, 0); add_dec(32'h00000073, 0);
        add_dec(32'h00007063, 1);

        rst_n = 1'b0; halt = 1'b1; irdy = 1'b0; drdy = 1'b0;
        regwr = 1'b1; memwr = 1'b1; inst = ADDI;
        @(negedge clk);
        check("reset_state", {4'h0, outs()}, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (rows[i]) run_row(rows[i]);

        foreach (decs[i]) begin
            apply_reset();
            inst = decs[i].inst; halt = 1'b0; irdy = 1'b1; drdy = 1'b1;
            regwr = 1'b1; memwr = 1'b1;
            repeat (3) tick();
            @(negedge clk);
            check($sformatf("decode_%h", decs[i].inst),
                  {10'h0, o_Stage, o_Illegal, o_RegWrEnable, o_MemWrEnable},
                  decs[i].legal ? {10'h0, 3'd3, 3'b000} : {10'h0, 3'd6, 3'b100});
        end

        // Illegal instruction: ERROR must hold with no strobes until reset
        apply_reset();
        inst = 32'hFFFFFFFF; halt = 1'b0; irdy = 1'b1; drdy = 1'b1; regwr = 1'b1; memwr = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("illegal_hold", {4'h0, outs()}, {4'h0, 3'd6, 7'b0, 2'b10});

        // Fetch timeout after 16 low-ready cycles
        apply_reset();
        inst = ADDI; halt = 1'b0; irdy = 1'b0;
        tick();
        fetch_cycles = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (o_Stage == 3'd1 && o_IMemReq) fetch_cycles++;
            tick();
        end
        check("imem_wait_cycles", 16'(fetch_cycles), 16'd16);
        @(negedge clk);
        check("imem_timeout", {12'h0, o_Stage, o_BusError}, {12'h0, 3'd6, 1'b1});
        check("imem_req_dropped", {15'h0, o_IMemReq}, 16'h0000);

        // Ready arrives in the limit cycle: no error
        apply_reset();
        inst = ADDI; halt = 1'b0; irdy = 1'b0;
        tick();
        repeat (15) tick();
        irdy = 1'b1;
        @(negedge clk);
        check("imem_ready_at_limit", {11'h0, o_Stage, o_IRLoad, o_BusError}, {11'h0, 3'd1, 2'b10});
        tick();
        @(negedge clk);
        check("imem_no_error", {12'h0, o_Stage, o_BusError}, {12'h0, 3'd2, 1'b0});

        // Data-side timeout on a store
        apply_reset();
        inst = SW; halt = 1'b0; irdy = 1'b1; drdy = 1'b0; memwr = 1'b1;
        repeat (4) tick();
        repeat (16) tick();
        @(negedge clk);
        check("dmem_timeout", {4'h0, outs()}, {4'h0, 3'd6, 7'b0, 2'b01});

        // Reset during the MEMORY stage of a load
        apply_reset();
        inst = LW; halt = 1'b0; irdy = 1'b1; drdy = 1'b0; regwr = 1'b1; memwr = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("lw_mem_req", {12'h0, o_Stage, o_DMemReq}, {12'h0, 3'd4, 1'b1});
        rst_n = 1'b0;
        #1;
        check("reset_async_drop", {4'h0, outs()}, 16'h0000);
        drdy = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_idle", {4'h0, outs()}, 16'h0000);
        tick();
        @(negedge clk);
        check("reset_then_fetch", {11'h0, o_Stage, o_IMemReq, o_RegWrEnable},
              {11'h0, 3'd1, 2'b10});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
